// File: rtl/color_det_pkg.sv
// rtl/color_det_pkg.sv - shared types and constants for the colour detector/tracker
package color_det_pkg;

  typedef enum logic [1:0] {
    SEL_R    = 2'd0,
    SEL_G    = 2'd1,
    SEL_B    = 2'd2,
    SEL_NONE = 2'd3
  } comp_sel_e;

  typedef struct packed {
    comp_sel_e  sel;
    logic [7:0] lo;
    logic [7:0] hi;
  } ch_cfg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int FLUSH_CYC = 2;

endpackage

// File: rtl/color_match_unit.sv
// rtl/color_match_unit.sv - combinational dominant-colour rule for one channel
module color_match_unit
  import color_det_pkg::*;
(
  input  logic [23:0] rgb,
  input  ch_cfg_t     cfg,
  output logic        match
);

  logic [7:0] d, o1, o2;
  logic       sel_ok;
  logic [8:0] osum;
  logic [9:0] d2;

  always_comb begin
    d      = 8'd0;
    o1     = 8'd0;
    o2     = 8'd0;
    sel_ok = 1'b1;
    case (cfg.sel)
      SEL_R:   begin d = rgb[23:16]; o1 = rgb[15:8];  o2 = rgb[7:0];  end
      SEL_G:   begin d = rgb[15:8];  o1 = rgb[23:16]; o2 = rgb[7:0];  end
      SEL_B:   begin d = rgb[7:0];   o1 = rgb[23:16]; o2 = rgb[15:8]; end
      default: sel_ok = 1'b0;
    endcase
    // widened so neither the sum nor the doubled dominant can wrap
    osum  = {1'b0, o1} + {1'b0, o2};
    d2    = {1'b0, d, 1'b0};
    match = sel_ok && (d > cfg.lo) && (d < cfg.hi) && !osum[8] && (d2 > {1'b0, osum});
  end

endmodule

// File: rtl/color_detect_track.sv
// rtl/color_detect_track.sv - multi-channel colour detector with per-frame count and bounding box
module color_detect_track
  import color_det_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int CNT_W     = 19,
  parameter int MIN_COUNT = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sof,
  input  logic                    eof,
  input  logic                    pix_valid,
  input  logic [23:0]             rgb_in,
  input  logic [X_W-1:0]          x_in,
  input  logic [Y_W-1:0]          y_in,
  input  logic [2*NUM_CH-1:0]     cfg_sel,
  input  logic [8*NUM_CH-1:0]     cfg_lo,
  input  logic [8*NUM_CH-1:0]     cfg_hi,
  output logic                    mask_valid,
  output logic [NUM_CH-1:0]       mask,
  output logic                    res_valid,
  output logic [NUM_CH-1:0]       found,
  output logic [CNT_W*NUM_CH-1:0] count,
  output logic [X_W*NUM_CH-1:0]   bbox_xmin,
  output logic [X_W*NUM_CH-1:0]   bbox_xmax,
  output logic [Y_W*NUM_CH-1:0]   bbox_ymin,
  output logic [Y_W*NUM_CH-1:0]   bbox_ymax
);

  state_e         state, state_nxt;
  logic [1:0]     flush_cnt;
  logic           start, do_report, acc_en;

  ch_cfg_t        shadow   [NUM_CH];
  ch_cfg_t        live_cfg [NUM_CH];
  logic [NUM_CH-1:0] match;

  logic           s1_valid;
  logic [23:0]    s1_rgb;
  logic [X_W-1:0] s1_x, s2_x;
  logic [Y_W-1:0] s1_y, s2_y;

  logic [CNT_W-1:0] acc_cnt  [NUM_CH];
  logic [X_W-1:0]   acc_xmin [NUM_CH];
  logic [X_W-1:0]   acc_xmax [NUM_CH];
  logic [Y_W-1:0]   acc_ymin [NUM_CH];
  logic [Y_W-1:0]   acc_ymax [NUM_CH];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign live_cfg[ch].sel = comp_sel_e'(cfg_sel[2*ch +: 2]);
    assign live_cfg[ch].lo  = cfg_lo[8*ch +: 8];
    assign live_cfg[ch].hi  = cfg_hi[8*ch +: 8];

    color_match_unit u_match (
      .rgb   (s1_rgb),
      .cfg   (shadow[ch]),
      .match (match[ch])
    );
  end

  // sof wins from any state: the running frame is dropped and restarted
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    if (sof) begin
      state_nxt = ACTIVE;
      start     = 1'b1;
    end else begin
      case (state)
        ACTIVE:  if (eof) state_nxt = FLUSH;
        FLUSH:   if (flush_cnt == 2'(FLUSH_CYC - 1)) state_nxt = REPORT;
        REPORT:  state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
    do_report = (state == REPORT) && !sof;
    acc_en    = ((state == ACTIVE) || (state == FLUSH)) && !start;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_rgb     <= '0;
      s1_x       <= '0;
      s1_y       <= '0;
      s2_x       <= '0;
      s2_y       <= '0;
      mask_valid <= 1'b0;
      mask       <= '0;
    end else begin
      s1_valid   <= pix_valid;
      s1_rgb     <= rgb_in;
      s1_x       <= x_in;
      s1_y       <= y_in;
      s2_x       <= s1_x;
      s2_y       <= s1_y;
      mask_valid <= s1_valid;
      mask       <= s1_valid ? match : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      found     <= '0;
      count     <= '0;
      bbox_xmin <= '0;
      bbox_xmax <= '0;
      bbox_ymin <= '0;
      bbox_ymax <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shadow[ch]   <= '0;
        acc_cnt[ch]  <= '0;
        acc_xmin[ch] <= '0;
        acc_xmax[ch] <= '0;
        acc_ymin[ch] <= '0;
        acc_ymax[ch] <= '0;
      end
    end else begin
      res_valid <= do_report;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (start) begin
          shadow[ch]   <= live_cfg[ch];
          acc_cnt[ch]  <= '0;
          acc_xmin[ch] <= '1;
          acc_xmax[ch] <= '0;
          acc_ymin[ch] <= '1;
          acc_ymax[ch] <= '0;
        end else if (acc_en && mask[ch]) begin
          if (acc_cnt[ch] != '1) acc_cnt[ch] <= acc_cnt[ch] + CNT_W'(1);
          if (s2_x < acc_xmin[ch]) acc_xmin[ch] <= s2_x;
          if (s2_x > acc_xmax[ch]) acc_xmax[ch] <= s2_x;
          if (s2_y < acc_ymin[ch]) acc_ymin[ch] <= s2_y;
          if (s2_y > acc_ymax[ch]) acc_ymax[ch] <= s2_y;
        end
        if (do_report) begin
          // an empty channel reports a zero box, not the cleared min/max sentinels
          count[ch*CNT_W +: CNT_W]   <= acc_cnt[ch];
          found[ch]                  <= (acc_cnt[ch] >= CNT_W'(MIN_COUNT));
          bbox_xmin[ch*X_W +: X_W]   <= (acc_cnt[ch] == '0) ? '0 : acc_xmin[ch];
          bbox_xmax[ch*X_W +: X_W]   <= (acc_cnt[ch] == '0) ? '0 : acc_xmax[ch];
          bbox_ymin[ch*Y_W +: Y_W]   <= (acc_cnt[ch] == '0) ? '0 : acc_ymin[ch];
          bbox_ymax[ch*Y_W +: Y_W]   <= (acc_cnt[ch] == '0) ? '0 : acc_ymax[ch];
        end
      end
    end
  end

endmodule

// File: tb/tb_color_detect_track.sv
// tb/tb_color_detect_track.sv - directed self-checking bench for color_detect_track
module tb_color_detect_track;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sof, eof, pix_valid;
  logic [23:0] rgb_in;
  logic [9:0]  x_in;
  logic [8:0]  y_in;
  logic [3:0]  cfg_sel;
  logic [15:0] cfg_lo, cfg_hi;
  logic        mask_valid, res_valid;
  logic [1:0]  mask, found;
  logic [37:0] count;
  logic [19:0] bbox_xmin, bbox_xmax;
  logic [17:0] bbox_ymin, bbox_ymax;

  int tests = 0;
  int fails = 0;
  int rv_cnt = 0;
  int rv_snap;
  bit seen;

  color_detect_track dut (
    .clk(clk), .reset_n(reset_n), .sof(sof), .eof(eof), .pix_valid(pix_valid),
    .rgb_in(rgb_in), .x_in(x_in), .y_in(y_in),
    .cfg_sel(cfg_sel), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .mask_valid(mask_valid), .mask(mask), .res_valid(res_valid), .found(found),
    .count(count), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (res_valid === 1'b1) rv_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_sof();
    sof = 1'b1; @(negedge clk); sof = 1'b0;
  endtask

  task automatic pulse_eof();
    eof = 1'b1; @(negedge clk); eof = 1'b0;
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [9:0] x, input logic [8:0] y);
    pix_valid = 1'b1; rgb_in = {r, g, b}; x_in = x; y_in = y;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_res(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) got = 1'b1;
    end
  endtask

  initial begin
    reset_n = 1'b0; sof = 0; eof = 0; pix_valid = 0; rgb_in = '0; x_in = '0; y_in = '0;
    cfg_sel = {2'd0, 2'd1};
    cfg_lo  = {8'h80, 8'h40};
    cfg_hi  = {8'hFF, 8'hE0};
    repeat (2) @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_mask", {mask_valid, mask}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_found_bbox", {found, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, 0);

    // detect latency and rule boundaries
    pulse_sof();
    pix(8'h20, 8'h80, 8'h20, 10'd1, 9'd1);
    chk("t1_lat1_valid", mask_valid, 0);
    @(negedge clk);
    chk("t1_mask_valid", mask_valid, 1);
    chk("t1_mask", mask, 2'b01);
    @(negedge clk);
    chk("t1_mask_clear", {mask_valid, mask}, 0);
    pix(8'h20, 8'h40, 8'h20, 10'd2, 9'd1); @(negedge clk);
    chk("t2_g_eq_lo", mask, 2'b00);
    pix(8'h20, 8'hE0, 8'h20, 10'd3, 9'd1); @(negedge clk);
    chk("t2_g_eq_hi", mask, 2'b00);
    pix(8'h90, 8'h80, 8'h70, 10'd4, 9'd1); @(negedge clk);
    chk("t2_sum256", mask, 2'b10);

    // abort via second sof, then 70-pixel frame
    pulse_sof();
    for (int i = 0; i < 70; i++)
      pix(8'h20, 8'h80, 8'h20, 10'(10 + (i % 31)), 9'(5 + (i % 5)));
    pulse_eof();
    #1 chk("t3_no_abort_report", rv_cnt, 0);
    @(negedge clk); chk("t3_res_e1", res_valid, 0);
    @(negedge clk); chk("t3_res_e2", res_valid, 0);
    @(negedge clk); chk("t3_res_e3", res_valid, 1);
    chk("t3_count0", count[18:0], 70);
    chk("t3_found", found, 2'b01);
    chk("t3_bbox0", {bbox_xmin[9:0], bbox_xmax[9:0], bbox_ymin[8:0], bbox_ymax[8:0]},
        {10'd10, 10'd40, 9'd5, 9'd9});
    chk("t3_ch1_empty", {count[37:19], bbox_xmin[19:10], bbox_xmax[19:10], bbox_ymin[17:9], bbox_ymax[17:9]}, 0);
    @(negedge clk); chk("t3_res_e4", res_valid, 0);

    // last pixel adjacent to eof
    pulse_sof();
    pix(8'h20, 8'h80, 8'h20, 10'd100, 9'd20);
    pix(8'h20, 8'h80, 8'h20, 10'd300, 9'd30);
    pix(8'h20, 8'h80, 8'h20, 10'd600, 9'd40);
    pulse_eof();
    wait_res(10, seen);
    chk("t4_seen", seen, 1);
    chk("t4_count0", count[18:0], 3);
    chk("t4_found", found, 2'b00);
    chk("t4_bbox0", {bbox_xmin[9:0], bbox_xmax[9:0], bbox_ymin[8:0], bbox_ymax[8:0]},
        {10'd100, 10'd600, 9'd20, 9'd40});

    // mid-frame cfg change takes effect on the next sof only
    pulse_sof();
    cfg_lo = {8'h80, 8'h90};
    pix(8'h20, 8'h80, 8'h20, 10'd50, 9'd50); @(negedge clk);
    chk("t5_old_rule", mask, 2'b01);
    pulse_eof();
    wait_res(10, seen);
    chk("t5_seen_a", seen, 1);
    chk("t5_count_a", count[18:0], 1);
    pulse_sof();
    pix(8'h20, 8'h80, 8'h20, 10'd50, 9'd50); @(negedge clk);
    chk("t5_new_rule", mask, 2'b00);
    pulse_eof();
    wait_res(10, seen);
    chk("t5_seen_b", seen, 1);
    chk("t5_zero_frame", {found, count, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, 0);
    cfg_lo = {8'h80, 8'h40};

    // asynchronous reset mid-frame
    pulse_sof();
    pix(8'h20, 8'h80, 8'h20, 10'd5, 9'd6);
    pix(8'h20, 8'h80, 8'h20, 10'd8, 9'd6);
    pulse_eof();
    wait_res(10, seen);
    chk("t6_pre_count", count[18:0], 2);
    pulse_sof();
    pix(8'h20, 8'h80, 8'h20, 10'd5, 9'd6);
    pix(8'h20, 8'h80, 8'h20, 10'd8, 9'd6);
    #2 reset_n = 1'b0;
    #1 chk("t6_async_clear", {mask_valid, mask, found, count, bbox_xmax}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulse_eof();
    repeat (6) @(negedge clk);
    rv_snap = rv_cnt;
    #1 chk("t6_no_partial_report", rv_cnt, 2 + 3);
    chk("t6_still_zero", count, 0);

    // second sof before eof restarts accumulation
    pulse_sof();
    for (int i = 0; i < 5; i++) pix(8'h20, 8'h80, 8'h20, 10'(200 + i), 9'd100);
    repeat (2) @(negedge clk);
    pulse_sof();
    pix(8'h20, 8'h80, 8'h20, 10'd7, 9'd3);
    pix(8'h20, 8'h80, 8'h20, 10'd9, 9'd4);
    pulse_eof();
    wait_res(10, seen);
    chk("t6_restart_seen", seen, 1);
    chk("t6_restart_count", count[18:0], 2);
    chk("t6_restart_bbox", {bbox_xmin[9:0], bbox_xmax[9:0], bbox_ymin[8:0], bbox_ymax[8:0]},
        {10'd7, 10'd9, 9'd3, 9'd4});
    @(negedge clk);
    #1 chk("t6_one_report", rv_cnt - rv_snap, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
